iissue_unit: RTL

- Instruction issue stage directly upstream of iexecution_unit.
- Accepts 32-bit vector instruction words from the fetch stage and buffers them in an in-order queue.
- Decodes register fields and checks a 32-entry vector-register scoreboard for hazards.
- Issues hazard-free instructions to the execution unit over a valid/ready handshake; execution writeback clears scoreboard entries.

---
 rtl/iissue_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/iissue_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : iissue_unit
// Description : In-order instruction issue stage. Buffers fetched vector
//               instructions, checks a 32-entry register scoreboard and
//               issues hazard-free heads to the execution unit.
// Revision    : 1.0 - initial release
// ============================================================================
module iissue_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_instr,
    output logic             fetch_ready,
    input  logic             flush,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [5:0]       issue_opcode,
    output logic [4:0]       issue_vd,
    output logic [4:0]       issue_vs1,
    output logic [4:0]       issue_vs2,
    output logic [10:0]      issue_imm,
    input  logic             wb_valid,
    input  logic [4:0]       wb_vd,
    output logic [CNT_W-1:0] issued_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);

    logic [31:0]        r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr;
    logic [c_ptr_w-1:0] r_rd;
    logic [c_cnt_w-1:0] r_count;
    logic [31:0]        r_busy;
    logic [CNT_W-1:0]   r_issued;
    logic [CNT_W-1:0]   r_stall;

    logic [31:0] w_head;
    logic        w_empty;
    logic [31:0] w_wb_mask;
    logic [31:0] w_set_mask;
    logic [31:0] w_busy_eff;
    logic        w_blocked;
    logic        w_push;
    logic        w_pop;

    assign w_head  = r_mem[r_rd];
    assign w_empty = (r_count == '0);

    // A same-cycle writeback releases its register before the hazard check.
    assign w_wb_mask  = wb_valid ? (32'd1 << wb_vd) : 32'd0;
    assign w_busy_eff = r_busy & ~w_wb_mask;
    assign w_blocked  = w_busy_eff[w_head[20:16]] | w_busy_eff[w_head[15:11]]
                      | w_busy_eff[w_head[25:21]];

    // Ready looks only at the registered count, so a pop on a full queue
    // does not open a slot until the following cycle.
    assign fetch_ready = reset && (r_count < c_full) && !flush;
    assign issue_valid = !w_empty && !w_blocked && !flush;

    // NOP words complete the handshake but never occupy a slot.
    assign w_push     = fetch_valid && fetch_ready && (fetch_instr[31:26] != 6'h00);
    assign w_pop      = issue_valid && issue_ready;
    assign w_set_mask = w_pop ? (32'd1 << w_head[25:21]) : 32'd0;

    assign issue_opcode = w_head[31:26];
    assign issue_vd     = w_head[25:21];
    assign issue_vs1    = w_head[20:16];
    assign issue_vs2    = w_head[15:11];
    assign issue_imm    = w_head[10:0];
    assign issued_count = r_issued;
    assign stall_count  = r_stall;

    // Queue storage: cleared on reset so the head fields read zero when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_push) begin
            r_mem[r_wr] <= fetch_instr;
        end
    end

    // Queue pointers and occupancy; flush collapses the queue to empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rd    <= r_wr;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Scoreboard: writeback clears, issue sets, and set wins on a collision.
    // Flush leaves it alone since in-flight results still return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= w_busy_eff | w_set_mask;
        end
    end

    // Saturating issue and stall status counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issued <= '0;
            r_stall  <= '0;
        end else begin
            if (w_pop && (r_issued != '1)) begin
                r_issued <= r_issued + 1'b1;
            end
            if (!w_empty && w_blocked && !flush && (r_stall != '1)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
